// File: rtl/fns_seq_decoder_if.sv
// Codeword-in / result-out handshake bundle for the Fibonacci-numeral decoder.
interface fns_seq_decoder_if #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 7
);
    logic [N-1:0] cw_in;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] val_out;
    logic         err_out;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output cw_in, in_valid, out_ready,
        input  in_ready, val_out, err_out, out_valid
    );

    modport slave (
        input  cw_in, in_valid, out_ready,
        output in_ready, val_out, err_out, out_valid
    );
endinterface

// File: rtl/fns_seq_decoder.sv
// Bit-serial Fibonacci-numeral-system decoder: one codeword bit per cycle,
// weights generated on the fly by a running add, sticky flag for adjacent 1s.
module fns_seq_decoder #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 7
) (
    input logic              clk,
    input logic              rst,
    fns_seq_decoder_if.slave bus
);
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [N-1:0]  cw_q, cw_nx;
    logic [W-1:0]  acc_q, acc_nx;
    logic [W-1:0]  w0_q, w0_nx;
    logic [W-1:0]  w1_q, w1_nx;
    logic [KW-1:0] k_q, k_nx;
    logic          err_q, err_nx;
    logic          prev_q, prev_nx;
    logic          in_ready_q, in_ready_nx;
    logic          out_valid_q, out_valid_nx;

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cw_q        <= '0;
            acc_q       <= '0;
            w0_q        <= '0;
            w1_q        <= '0;
            k_q         <= '0;
            err_q       <= 1'b0;
            prev_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nx;
            cw_q        <= cw_nx;
            acc_q       <= acc_nx;
            w0_q        <= w0_nx;
            w1_q        <= w1_nx;
            k_q         <= k_nx;
            err_q       <= err_nx;
            prev_q      <= prev_nx;
            in_ready_q  <= in_ready_nx;
            out_valid_q <= out_valid_nx;
        end
    end

    // Next-state and datapath update; the codeword is shifted so bit k sits at cw_q[0].
    always_comb begin
        state_nx     = state;
        cw_nx        = cw_q;
        acc_nx       = acc_q;
        w0_nx        = w0_q;
        w1_nx        = w1_q;
        k_nx         = k_q;
        err_nx       = err_q;
        prev_nx      = prev_q;
        in_ready_nx  = in_ready_q;
        out_valid_nx = out_valid_q;

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nx    = RUN;
                    cw_nx       = bus.cw_in;
                    acc_nx      = '0;
                    err_nx      = 1'b0;
                    prev_nx     = 1'b0;
                    k_nx        = '0;
                    w0_nx       = W'(1);
                    w1_nx       = W'(2);
                    in_ready_nx = 1'b0;
                end
            end
            RUN: begin
                if (cw_q[0]) begin
                    acc_nx = acc_q + w0_q;
                end
                // prev_q is cleared on accept, so bit 0 can never flag an error
                if (cw_q[0] && prev_q) begin
                    err_nx = 1'b1;
                end
                prev_nx = cw_q[0];
                cw_nx   = cw_q >> 1;
                w0_nx   = w1_q;
                w1_nx   = w0_q + w1_q;
                k_nx    = k_q + KW'(1);
                if (k_q == KW'(N - 1)) begin
                    state_nx     = DONE;
                    out_valid_nx = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx     = IDLE;
                    out_valid_nx = 1'b0;
                    in_ready_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.val_out   = acc_q;
    assign bus.err_out   = err_q;
endmodule

// File: tb/tb_fns_seq_decoder.sv
// Scoreboard bench for fns_seq_decoder: driver pushes model results on accept,
// a negedge monitor pops and compares whenever a result is presented.
module tb_fns_seq_decoder;
    localparam int unsigned N = 8;
    localparam int unsigned W = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fns_seq_decoder_if #(.N(N), .W(W)) bus ();
    fns_seq_decoder #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [W-1:0] val;
        logic         err;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: value is the sum of Fibonacci numbers F(k+2) over set bits;
    // non-canonical means any two adjacent set bits.
    function automatic exp_t model(input logic [N-1:0] cw);
        exp_t e;
        int   f[N+3];
        int   sum;
        f[0] = 0;
        f[1] = 1;
        f[2] = 1;
        for (int i = 3; i < N + 3; i++) f[i] = f[i-1] + f[i-2];
        sum = 0;
        for (int k = 0; k < N; k++) if (cw[k]) sum += f[k+2];
        e.val     = W'(sum);
        e.err     = |(cw & (cw >> 1));
        e.acc_cyc = 0;
        return e;
    endfunction

    // Monitor: latency on rise, hold stability under backpressure, pop on consume.
    logic         held    = 1'b0;
    logic         ov_prev = 1'b0;
    logic [W-1:0] hv;
    logic         he;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.out_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: got val %0d err %0d, expected no output", bus.val_out, bus.err_out);
            end else begin
                if (!ov_prev) check("latency", 32'(cyc - sb[0].acc_cyc), N);
                check("in_ready_in_done", 32'(bus.in_ready), 0);
                if (held) begin
                    check("hold_val", 32'(bus.val_out), 32'(hv));
                    check("hold_err", 32'(bus.err_out), 32'(he));
                end
                if (bus.out_ready) begin
                    e = sb.pop_front();
                    check("val_out", 32'(bus.val_out), 32'(e.val));
                    check("err_out", 32'(bus.err_out), 32'(e.err));
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hv   = bus.val_out;
                    he   = bus.err_out;
                end
            end
        end else begin
            held = 1'b0;
        end
        ov_prev = bus.out_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] cw, input bit push, input bit hold_valid, output int acc);
        exp_t e;
        int   n = 0;
        acc = -1;
        while (!bus.in_ready && n < 200) begin
            step();
            n++;
        end
        check("accept_wait", 32'(bus.in_ready), 1);
        if (!bus.in_ready) return;
        bus.cw_in    = cw;
        bus.in_valid = 1'b1;
        step();
        acc = cyc;
        if (push) begin
            e         = model(cw);
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        if (hold_valid) bus.cw_in = N'($urandom);
        else            bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            step();
            n++;
        end
        check("drain", 32'(sb.size()), 0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : main
        logic [N-1:0] dir[7];
        int acc, prev, n, seen;
        dir = '{8'h01, 8'h80, 8'hAA, 8'h55, 8'hFF, 8'h03, 8'h00};

        // Reset with in_valid asserted: reset must win, nothing accepted.
        bus.cw_in     = 8'hFF;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (3) step();
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_val_out", 32'(bus.val_out), 0);
        check("rst_err_out", 32'(bus.err_out), 0);
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        step();

        // Directed single-bit, canonical and non-canonical codewords.
        foreach (dir[i]) send(dir[i], 1'b1, 1'b0, acc);
        drain();

        // Backpressure: hold result for 5 cycles while in_valid toggles cw_in.
        bus.out_ready = 1'b0;
        send(8'h2A, 1'b1, 1'b0, acc);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            step();
            n++;
        end
        check("bp_out_valid", 32'(bus.out_valid), 1);
        repeat (5) begin
            bus.in_valid = 1'b1;
            bus.cw_in    = N'($urandom);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("bp_idle_in_ready", 32'(bus.in_ready), 1);
        check("bp_idle_out_valid", 32'(bus.out_valid), 0);
        send(8'h14, 1'b1, 1'b0, acc);
        drain();

        // Reset mid-RUN aborts the codeword; next codeword decodes cleanly.
        send(8'hFF, 1'b0, 1'b0, acc);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst  = 1'b0;
        seen = 0;
        repeat (N + 2) begin
            if (bus.out_valid) seen++;
            step();
        end
        check("abort_no_output", 32'(seen), 0);
        check("abort_in_ready", 32'(bus.in_ready), 1);
        send(8'h05, 1'b1, 1'b0, acc);
        drain();

        // Back-to-back: each codeword spends N RUN cycles, one DONE and one IDLE.
        prev = -1;
        for (int i = 0; i < 10; i++) begin
            send(N'($urandom), 1'b1, 1'b1, acc);
            if (prev >= 0) check("accept_spacing", 32'(acc - prev), N + 2);
            prev = acc;
        end
        bus.in_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
